// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage for the single-cycle MIPS datapath
//
// Holds the PC, reads the word-addressed instruction ROM and presents the
// current instruction, its opcode and the PC to the decode stage. Branch from
// control_unit and zero from the ALU select a taken branch; stall holds the PC;
// a HALT opcode parks the unit until reset.
//
// Optional feature macro: JUMP_EN
//   defined   : opcode 6'b000010 (j) loads {pc_plus4[31:28], instr[25:0], 2'b00}
//   undefined : opcode 6'b000010 is treated like any other opcode
//
// Parameters
//   IMEM_DEPTH  ROM depth in 32-bit words (power of 2)
//   IMEM_FILE   name of the ROM image; the array `rom` is loaded from it
//               by the environment before reset is released
//   RESET_PC    PC after reset (bits [1:0] forced to 0)
//   HALT_OP     opcode that stops fetching
//
// Ports
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset
//   stall     in   1   hold PC and outputs this cycle
//   branch    in   1   control_unit Branch
//   zero      in   1   ALU zero flag
//   instr     out  32  current instruction (0 when valid=0)
//   opcode    out  6   instr[31:26]
//   pc        out  32  address of instr
//   pc_plus4  out  32  pc + 4, mod 2^32
//   valid     out  1   instr is a live instruction
//   halted    out  1   HALT state reached

module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter              IMEM_FILE  = "imem.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        valid,
  output logic        halted
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [5:0]  J_OP = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t state;

  // Instruction ROM. Contents come from the IMEM_FILE image.
  logic [31:0] rom [IMEM_DEPTH];

  logic [AW-1:0] rom_idx;
  logic [31:0]   rom_word;
  logic [5:0]    rom_op;
  logic [31:0]   branch_off;
  logic [31:0]   branch_target;
  logic          in_run;

  // Upper PC bits are ignored so the ROM aliases modulo IMEM_DEPTH.
  assign rom_idx  = pc[AW+1:2];
  assign rom_word = rom[rom_idx];
  assign rom_op   = rom_word[31:26];

  assign pc_plus4      = pc + 32'd4;
  assign branch_off    = {{14{rom_word[15]}}, rom_word[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;

`ifdef JUMP_EN
  logic [31:0] jump_target;
  assign jump_target = {pc_plus4[31:28], rom_word[25:0], 2'b00};
`endif

  // Outputs depend only on registered state and pc, never on stall/branch/zero.
  assign in_run = (state == S_RUN);
  assign valid  = in_run;
  assign halted = (state == S_HALT);
  assign instr  = in_run ? rom_word : 32'h0000_0000;
  assign opcode = instr[31:26];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC_ALIGNED;
    end else begin
      case (state)
        // One dead cycle after reset; inputs are ignored here.
        S_IDLE: state <= S_RUN;

        S_RUN: begin
          // A stalled cycle drops any branch; decode re-asserts it later.
          if (!stall) begin
            if (rom_op == HALT_OP) begin
              state <= S_HALT;
`ifdef JUMP_EN
            end else if (rom_op == J_OP) begin
              pc <= jump_target;
`endif
            end else if (branch && zero) begin
              pc <= branch_target;
            end else begin
              pc <= pc_plus4;
            end
          end
        end

        // Parked until reset; pc stays on the HALT instruction.
        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        valid;
  logic        halted;

  int checks;
  int failures;

  instr_fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .branch   (branch),
    .zero     (zero),
    .instr    (instr),
    .opcode   (opcode),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .valid    (valid),
    .halted   (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Filler word k: opcode 0, imm = k, so instr identifies the ROM slot.
  task automatic load_filler();
    for (int i = 0; i < 256; i++) dut.rom[i] = 32'h0100_0000 | 32'(i);
  endtask

  // Leaves the DUT in RUN with pc = 0, at a negative edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    load_filler();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (opcode !== 6'h0) begin failures++; $display("FAIL rst_opcode got=%h exp=0", opcode); end
    rst = 1'b0;
    // Cycle 1 after release: IDLE. Inputs driven here must be ignored.
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", valid); end
    stall = 1'b1; branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    stall = 1'b0; branch = 1'b0; zero = 1'b0;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL run_valid got=%b exp=1", valid); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL run_pc0 got=%h exp=0", pc); end
    checks++; if (instr !== 32'h0100_0000) begin failures++; $display("FAIL run_instr0 got=%h exp=%h", instr, 32'h0100_0000); end
    checks++; if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL run_pc_plus4 got=%h exp=4", pc_plus4); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (pc !== 32'(4 * k)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", k, pc, 32'(4 * k)); end
      checks++; if (instr !== (32'h0100_0000 | 32'(k))) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", k, instr, 32'h0100_0000 | 32'(k)); end
    end
  endtask

  task automatic test_branch();
    load_filler();
    dut.rom[2] = 32'h0100_0003;
    do_reset();
    repeat (2) @(negedge clk);
    checks++; if (instr !== 32'h0100_0003) begin failures++; $display("FAIL br_instr got=%h exp=%h", instr, 32'h0100_0003); end
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'd24) begin failures++; $display("FAIL br_taken got=%h exp=%h", pc, 32'd24); end
    checks++; if (instr !== 32'h0100_0006) begin failures++; $display("FAIL br_taken_instr got=%h exp=%h", instr, 32'h0100_0006); end

    do_reset();
    repeat (2) @(negedge clk);
    branch = 1'b1; zero = 1'b0;
    @(negedge clk);
    checks++; if (pc !== 32'd12) begin failures++; $display("FAIL br_zero0 got=%h exp=%h", pc, 32'd12); end
    branch = 1'b0; zero = 1'b1;
    @(negedge clk);
    checks++; if (pc !== 32'd16) begin failures++; $display("FAIL br_branch0 got=%h exp=%h", pc, 32'd16); end

    // Reset wins over a pending taken branch.
    branch = 1'b1; zero = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL br_rst_pc got=%h exp=0", pc); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL br_rst_valid got=%b exp=0", valid); end
  endtask

  task automatic test_stall();
    load_filler();
    dut.rom[10] = 32'hFC00_0000;
    do_reset();
    repeat (4) @(negedge clk);
    stall = 1'b1; branch = 1'b1; zero = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (pc !== 32'd16) begin failures++; $display("FAIL stall_pc%0d got=%h exp=%h", k, pc, 32'd16); end
      checks++; if (instr !== 32'h0100_0004) begin failures++; $display("FAIL stall_instr%0d got=%h exp=%h", k, instr, 32'h0100_0004); end
    end
    stall = 1'b0;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'd36) begin failures++; $display("FAIL stall_rebranch got=%h exp=%h", pc, 32'd36); end
    @(negedge clk);
    checks++; if (pc !== 32'd40) begin failures++; $display("FAIL stall_seq got=%h exp=%h", pc, 32'd40); end
    checks++; if (opcode !== 6'h3F) begin failures++; $display("FAIL stall_haltop got=%h exp=3f", opcode); end
    // Stall outranks HALT.
    stall = 1'b1;
    @(negedge clk);
    checks++; if (halted !== 1'b0 || valid !== 1'b1 || pc !== 32'd40) begin
      failures++; $display("FAIL stall_over_halt got=h%b v%b pc=%h exp=h0 v1 pc=28", halted, valid, pc);
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL stall_then_halt got=%b exp=1", halted); end
  endtask

  task automatic test_wrap();
    load_filler();
    dut.rom[0] = 32'h0100_FFFF;
    do_reset();
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_self got=%h exp=0", pc); end
    checks++; if (instr !== 32'h0100_FFFF) begin failures++; $display("FAIL wrap_self_instr got=%h exp=%h", instr, 32'h0100_FFFF); end

    dut.rom[0] = 32'h0100_FFFE;
    do_reset();
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_neg_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    checks++; if (instr !== 32'h0100_00FF) begin failures++; $display("FAIL wrap_neg_instr got=%h exp=%h", instr, 32'h0100_00FF); end
    checks++; if (pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_plus4 got=%h exp=0", pc_plus4); end
    @(negedge clk);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap_roll got=%h exp=0", pc); end

    dut.rom[0] = 32'h0100_00FE;
    do_reset();
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== 32'd1020) begin failures++; $display("FAIL wrap_1020 got=%h exp=%h", pc, 32'd1020); end
    checks++; if (instr !== 32'h0100_00FF) begin failures++; $display("FAIL wrap_1020_instr got=%h exp=%h", instr, 32'h0100_00FF); end
    @(negedge clk);
    checks++; if (pc !== 32'd1024) begin failures++; $display("FAIL wrap_1024 got=%h exp=%h", pc, 32'd1024); end
    checks++; if (instr !== 32'h0100_00FE) begin failures++; $display("FAIL wrap_alias got=%h exp=%h", instr, 32'h0100_00FE); end
  endtask

  task automatic test_halt();
    load_filler();
    dut.rom[3] = 32'hFC00_0000;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (opcode !== 6'h3F || valid !== 1'b1) begin failures++; $display("FAIL halt_fetch got=op%h v%b exp=op3f v1", opcode, valid); end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++; if (halted !== 1'b1 || valid !== 1'b0 || instr !== 32'h0 || opcode !== 6'h0 || pc !== 32'd12) begin
        failures++; $display("FAIL halt_hold%0d got=h%b v%b i=%h op=%h pc=%h exp=h1 v0 i=0 op=0 pc=c", k, halted, valid, instr, opcode, pc);
      end
      branch = 1'b1; zero = 1'b1; stall = k[0];
      @(negedge clk);
    end
    branch = 1'b0; zero = 1'b0; stall = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (halted !== 1'b0 || valid !== 1'b0 || pc !== 32'h0) begin
      failures++; $display("FAIL halt_rst got=h%b v%b pc=%h exp=h0 v0 pc=0", halted, valid, pc);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== 32'h0) begin failures++; $display("FAIL halt_restart got=v%b pc=%h exp=v1 pc=0", valid, pc); end
  endtask

  task automatic test_jump();
    logic [31:0] exp_plain;
    logic [31:0] exp_br;
`ifdef JUMP_EN
    exp_plain = 32'h40;
    exp_br    = 32'h40;
`else
    exp_plain = 32'h8;
    exp_br    = 32'd72;
`endif
    load_filler();
    dut.rom[1] = 32'h0800_0010;
    do_reset();
    @(negedge clk);
    checks++; if (opcode !== 6'h02) begin failures++; $display("FAIL jump_op got=%h exp=02", opcode); end
    @(negedge clk);
    checks++; if (pc !== exp_plain) begin failures++; $display("FAIL jump_plain got=%h exp=%h", pc, exp_plain); end

    do_reset();
    @(negedge clk);
    branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    branch = 1'b0; zero = 1'b0;
    checks++; if (pc !== exp_br) begin failures++; $display("FAIL jump_vs_branch got=%h exp=%h", pc, exp_br); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0;
    test_reset();
    test_branch();
    test_stall();
    test_wrap();
    test_halt();
    test_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
